// File: rtl/rate_sequence_ctrl.sv
// Rate sequencer: steps through a small stored program of {speed, dwell} entries and
// emits a one-cycle Tick at the period selected by each step's speed code.
module rate_sequence_ctrl #(
   parameter  int CLOCK_FREQUENCY = 500,
   parameter  int NUM_STEPS       = 4,
   parameter  int DWELL_W         = 8,
   localparam int STEP_W          = $clog2(NUM_STEPS),
   localparam int DIV_W           = $clog2(4*CLOCK_FREQUENCY+1)
) (
   input  logic               ClockIn,
   input  logic               Resetn,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Pause,
   input  logic               Loop,
   input  logic               ProgWrite,
   input  logic [STEP_W-1:0]  ProgAddr,
   input  logic [1:0]         ProgSpeed,
   input  logic [DWELL_W-1:0] ProgDwell,
   output logic               Tick,
   output logic [1:0]         Speed,
   output logic [STEP_W-1:0]  Step,
   output logic               Busy,
   output logic               Done,
   output logic [2:0]         StateDbg
);

   // Start/Stop are single-cycle strobes and ProgWrite a write strobe, all sampled on
   // ClockIn with no backpressure; Pause is a level.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSED = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS-1);

   state_t               state, state_nxt;
   logic [STEP_W-1:0]    step, step_nxt;
   logic [1:0]           speed, speed_nxt;
   logic [DWELL_W-1:0]   dwell_cnt, dwell_nxt;
   logic [DIV_W-1:0]     div_cnt, div_nxt;
   logic                 pass_tick, pass_nxt;
   logic                 tick_c;
   logic                 advance;
   logic                 pass_any;

   logic [1:0]           prog_speed [NUM_STEPS];
   logic [DWELL_W-1:0]   prog_dwell [NUM_STEPS];
   logic [1:0]           entry_speed;
   logic [DWELL_W-1:0]   entry_dwell;

   function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] code);
      case (code)
         2'b00:   period_m1 = '0;
         2'b01:   period_m1 = DIV_W'(CLOCK_FREQUENCY-1);
         2'b10:   period_m1 = DIV_W'(2*CLOCK_FREQUENCY-1);
         default: period_m1 = DIV_W'(4*CLOCK_FREQUENCY-1);
      endcase
   endfunction

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            prog_speed[i] <= 2'b00;
            prog_dwell[i] <= '0;
         end
      end else if (ProgWrite) begin
         prog_speed[ProgAddr] <= ProgSpeed;
         prog_dwell[ProgAddr] <= ProgDwell;
      end
   end

   // LOAD reads the array before any same-cycle write lands, so it sees the old entry.
   assign entry_speed = prog_speed[step];
   assign entry_dwell = prog_dwell[step];

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         state     <= ST_IDLE;
         step      <= '0;
         speed     <= 2'b00;
         dwell_cnt <= '0;
         div_cnt   <= '0;
         pass_tick <= 1'b0;
      end else begin
         state     <= state_nxt;
         step      <= step_nxt;
         speed     <= speed_nxt;
         dwell_cnt <= dwell_nxt;
         div_cnt   <= div_nxt;
         pass_tick <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      speed_nxt = speed;
      dwell_nxt = dwell_cnt;
      div_nxt   = div_cnt;
      pass_nxt  = pass_tick;
      tick_c    = 1'b0;
      advance   = 1'b0;
      pass_any  = pass_tick;

      if (Stop) begin
         state_nxt = ST_IDLE;
         step_nxt  = '0;
         speed_nxt = 2'b00;
         pass_nxt  = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  state_nxt = ST_LOAD;
                  step_nxt  = '0;
                  pass_nxt  = 1'b0;
               end
            end
            ST_LOAD: begin
               speed_nxt = entry_speed;
               dwell_nxt = entry_dwell;
               div_nxt   = period_m1(entry_speed);
               if (entry_dwell != '0) state_nxt = ST_RUN;
               else                   advance   = 1'b1;
            end
            ST_RUN: begin
               // Pause is decided first so a pending Tick waits for the resume.
               if (Pause) begin
                  state_nxt = ST_PAUSED;
               end else if (div_cnt == '0) begin
                  tick_c    = 1'b1;
                  pass_any  = 1'b1;
                  pass_nxt  = 1'b1;
                  div_nxt   = period_m1(speed);
                  dwell_nxt = dwell_cnt - DWELL_W'(1);
                  if (dwell_cnt == DWELL_W'(1)) advance = 1'b1;
               end else begin
                  div_nxt = div_cnt - DIV_W'(1);
               end
            end
            ST_PAUSED: begin
               if (!Pause) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
         endcase

         // A pass with no Tick cannot loop, so an all-zero program always reaches DONE.
         if (advance) begin
            if (step != LAST_STEP) begin
               step_nxt  = step + STEP_W'(1);
               state_nxt = ST_LOAD;
            end else if (Loop && pass_any) begin
               step_nxt  = '0;
               pass_nxt  = 1'b0;
               state_nxt = ST_LOAD;
            end else begin
               state_nxt = ST_DONE;
            end
         end
      end
   end

   assign Tick     = tick_c;
   assign Speed    = speed;
   assign Step     = step;
   assign Busy     = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_PAUSED);
   assign Done     = (state == ST_DONE);
   assign StateDbg = state;

endmodule

// File: tb/tb_rate_sequence_ctrl.sv
// Bench for rate_sequence_ctrl: directed scenarios plus randomized programs, checked
// cycle by cycle against a step-level model that expands each LOADed entry into cycles.
module tb_rate_sequence_ctrl;

   localparam int CF = 4;
   localparam int NS = 4;
   localparam int DW = 8;
   localparam int SW = 2;

   localparam logic [1:0] K_LOAD = 2'd0;
   localparam logic [1:0] K_RUN  = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [SW-1:0] step;
      logic [1:0]    speed;
      logic          tick;
   } rec_t;

   logic          clock_in;
   logic          resetn;
   logic          start, stop, pause, loop_en, prog_write;
   logic [SW-1:0] prog_addr;
   logic [1:0]    prog_speed;
   logic [DW-1:0] prog_dwell;
   logic          tick;
   logic [1:0]    speed;
   logic [SW-1:0] step;
   logic          busy, done;
   logic [2:0]    state_dbg;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   mem_s [NS];
   int   mem_d [NS];
   rec_t exp_q [$];
   bit   m_paused;
   int   pass_ticks;
   int   done_cycle;
   int   tick_count;
   int   tick_cycles [$];
   int   stop_at, pause_from, pause_len, pause_pct, wr_at, wr_a, wr_s, wr_d, wr_pct;

   rate_sequence_ctrl #(
      .CLOCK_FREQUENCY (CF),
      .NUM_STEPS       (NS),
      .DWELL_W         (DW)
   ) dut (
      .ClockIn   (clock_in),
      .Resetn    (resetn),
      .Start     (start),
      .Stop      (stop),
      .Pause     (pause),
      .Loop      (loop_en),
      .ProgWrite (prog_write),
      .ProgAddr  (prog_addr),
      .ProgSpeed (prog_speed),
      .ProgDwell (prog_dwell),
      .Tick      (tick),
      .Speed     (speed),
      .Step      (step),
      .Busy      (busy),
      .Done      (done),
      .StateDbg  (state_dbg)
   );

   // clock / reset
   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   function automatic int period_of(input int code);
      return (code == 0) ? 1 : (CF << (code - 1));
   endfunction

   // Expand a LOADed entry into its RUN cycles and the record that follows it.
   function automatic void expand_load(input int s);
      int   d, sp, p;
      rec_t r;
      d  = mem_d[s];
      sp = mem_s[s];
      p  = period_of(sp);
      for (int i = 1; i <= d * p; i++) begin
         r.kind = K_RUN; r.step = SW'(s); r.speed = 2'(sp); r.tick = ((i % p) == 0);
         exp_q.push_back(r);
      end
      pass_ticks += d;
      r.tick = 1'b0;
      if (s < NS - 1) begin
         r.kind = K_LOAD; r.step = SW'(s + 1); r.speed = 2'b00;
      end else if (loop_en && pass_ticks > 0) begin
         pass_ticks = 0;
         r.kind = K_LOAD; r.step = '0; r.speed = 2'b00;
      end else begin
         r.kind = K_DONE; r.step = SW'(NS - 1); r.speed = 2'(sp);
      end
      exp_q.push_back(r);
   endfunction

   // driver tasks
   task automatic clear_knobs();
      stop_at = 0; pause_from = 0; pause_len = 0; pause_pct = 0;
      wr_at = 0; wr_a = 0; wr_s = 0; wr_d = 0; wr_pct = 0;
   endtask

   task automatic prog_entry(input int a, input int s, input int d);
      prog_write = 1'b1; prog_addr = SW'(a); prog_speed = 2'(s); prog_dwell = DW'(d);
      @(posedge clock_in); #1;
      prog_write = 1'b0;
      mem_s[a] = s; mem_d[a] = d;
   endtask

   task automatic start_run(input bit lp);
      rec_t r;
      loop_en = lp;
      start   = 1'b1;
      exp_q.delete();
      r.kind = K_LOAD; r.step = '0; r.speed = 2'b00; r.tick = 1'b0;
      exp_q.push_back(r);
      m_paused   = 1'b0;
      pass_ticks = 0;
      @(posedge clock_in); #1;
      start = 1'b0;
   endtask

   // scoreboard: cycle n is the n-th cycle after the Start edge
   task automatic scoreboard_run(input int max_cyc, input bit need_done, input string name);
      rec_t          r;
      bit            p, wr, done_hit, chk_speed;
      logic          e_tick, e_busy, e_done;
      logic [SW-1:0] e_step;
      logic [1:0]    e_speed;
      int            wa, ws, wd;
      done_cycle = -1; tick_count = 0; tick_cycles.delete(); done_hit = 1'b0;
      wa = 0; ws = 0; wd = 0;
      for (int n = 1; n <= max_cyc; n++) begin
         if (n == stop_at) begin
            stop = 1'b1; pause = 1'b0;
            @(negedge clock_in);
            @(posedge clock_in); #1;
            stop = 1'b0;
            return;
         end
         p = ((n >= pause_from) && (n < pause_from + pause_len)) ||
             (int'($urandom_range(0, 99)) < pause_pct);
         pause = p;
         wr = 1'b0;
         if (n == wr_at) begin
            wr = 1'b1; wa = wr_a; ws = wr_s; wd = wr_d;
         end else if (int'($urandom_range(0, 99)) < wr_pct) begin
            wr = 1'b1;
            wa = int'($urandom_range(0, NS - 1));
            ws = int'($urandom_range(0, 3));
            wd = int'($urandom_range(0, 3));
         end
         if (wr) begin
            prog_write = 1'b1; prog_addr = SW'(wa); prog_speed = 2'(ws); prog_dwell = DW'(wd);
         end
         @(negedge clock_in);
         if (tick === 1'b1) begin
            tick_count++;
            tick_cycles.push_back(n);
         end
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s model_empty cycle %0d", name, n);
            pause = 1'b0; prog_write = 1'b0;
            return;
         end
         r = exp_q[0];
         chk_speed = 1'b1; e_step = r.step; e_speed = r.speed;
         e_tick = 1'b0; e_busy = 1'b1; e_done = 1'b0;
         if (m_paused) begin
            if (!p) m_paused = 1'b0;
         end else if (r.kind == K_RUN && p) begin
            m_paused = 1'b1;
         end else begin
            case (r.kind)
               K_LOAD: begin
                  chk_speed = 1'b0;
                  void'(exp_q.pop_front());
                  expand_load(int'(r.step));
               end
               K_RUN: begin
                  e_tick = r.tick;
                  void'(exp_q.pop_front());
               end
               default: begin
                  e_busy = 1'b0; e_done = 1'b1; done_hit = 1'b1;
               end
            endcase
         end
         n_checks++;
         if (tick !== e_tick) begin
            n_fail++; $display("FAIL %s tick cycle %0d: got %b want %b", name, n, tick, e_tick);
         end
         n_checks++;
         if (busy !== e_busy) begin
            n_fail++; $display("FAIL %s busy cycle %0d: got %b want %b", name, n, busy, e_busy);
         end
         n_checks++;
         if (done !== e_done) begin
            n_fail++; $display("FAIL %s done cycle %0d: got %b want %b", name, n, done, e_done);
         end
         n_checks++;
         if (step !== e_step) begin
            n_fail++; $display("FAIL %s step cycle %0d: got %0d want %0d", name, n, step, e_step);
         end
         if (chk_speed) begin
            n_checks++;
            if (speed !== e_speed) begin
               n_fail++; $display("FAIL %s speed cycle %0d: got %0d want %0d", name, n, speed, e_speed);
            end
         end
         @(posedge clock_in); #1;
         if (wr) begin
            prog_write = 1'b0;
            mem_s[wa] = ws; mem_d[wa] = wd;
         end
         if (done_hit) begin
            done_cycle = n; pause = 1'b0;
            return;
         end
      end
      pause = 1'b0;
      if (need_done) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: no DONE within %0d cycles", name, max_cyc);
      end
   endtask

   task automatic check_ticks(input string name, input int exp_t[$]);
      n_checks++;
      if (tick_cycles.size() < exp_t.size()) begin
         n_fail++;
         $display("FAIL %s tick_list: got %0d ticks want at least %0d", name, tick_cycles.size(), exp_t.size());
      end else begin
         for (int i = 0; i < exp_t.size(); i++) begin
            n_checks++;
            if (tick_cycles[i] != exp_t[i]) begin
               n_fail++;
               $display("FAIL %s tick_%0d: got cycle %0d want cycle %0d", name, i, tick_cycles[i], exp_t[i]);
            end
         end
      end
   endtask

   task automatic check_idle(input string name);
      n_checks++;
      if ({tick, speed, step, busy, done} !== {1'b0, 2'b00, {SW{1'b0}}, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s idle_outputs: got tick=%b speed=%0d step=%0d busy=%b done=%b want all 0",
                  name, tick, speed, step, busy, done);
      end
   endtask

   task automatic test_reset();
      #12;
      check_idle("reset_asserted");
      @(negedge clock_in); resetn = 1'b1;
      @(posedge clock_in); #1;
      @(negedge clock_in);
      check_idle("reset_released");
      @(posedge clock_in); #1;
   endtask

   task automatic program_example();
      prog_entry(0, 1, 2);
      prog_entry(1, 3, 1);
      prog_entry(2, 0, 3);
      prog_entry(3, 2, 0);
   endtask

   task automatic test_single_pass();
      clear_knobs();
      program_example();
      start_run(1'b0);
      scoreboard_run(200, 1'b1, "single_pass");
      // Step 3's LOAD cycle sits between the last Tick (cycle 30) and DONE.
      check_ticks("single_pass", '{5, 9, 26, 28, 29, 30});
      n_checks++;
      if (tick_count != 6) begin
         n_fail++; $display("FAIL single_pass tick_count: got %0d want 6", tick_count);
      end
      n_checks++;
      if (done_cycle != 32) begin
         n_fail++; $display("FAIL single_pass done_cycle: got %0d want 32", done_cycle);
      end
   endtask

   task automatic test_start_stop();
      start = 1'b1; stop = 1'b1;
      @(posedge clock_in); #1;
      start = 1'b0; stop = 1'b0;
      @(negedge clock_in);
      check_idle("start_stop");
      repeat (3) @(posedge clock_in);
      @(negedge clock_in);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL start_stop later_busy: got %b want 0", busy);
      end
      @(posedge clock_in); #1;
   endtask

   task automatic test_loop_stop();
      clear_knobs();
      stop_at = 45;
      start_run(1'b1);
      scoreboard_run(100, 1'b0, "loop_stop");
      check_ticks("loop_stop", '{5, 9, 26, 28, 29, 30, 36, 40});
      @(negedge clock_in);
      check_idle("after_stop");
      @(posedge clock_in); #1;
   endtask

   task automatic test_zero_dwell();
      clear_knobs();
      prog_entry(0, 1, 0);
      prog_entry(1, 2, 0);
      prog_entry(2, 3, 0);
      prog_entry(3, 1, 0);
      start_run(1'b1);
      scoreboard_run(50, 1'b1, "zero_dwell");
      n_checks++;
      if (done_cycle != 5 || tick_count != 0) begin
         n_fail++; $display("FAIL zero_dwell done_cycle/ticks: got %0d/%0d want 5/0", done_cycle, tick_count);
      end
   endtask

   task automatic test_pause();
      clear_knobs();
      prog_entry(0, 2, 2);
      prog_entry(1, 0, 0);
      prog_entry(2, 0, 0);
      prog_entry(3, 0, 0);
      pause_from = 6; pause_len = 10;
      start_run(1'b0);
      scoreboard_run(100, 1'b1, "pause");
      check_ticks("pause", '{20, 28});
      n_checks++;
      if (tick_count != 2 || done_cycle != 32) begin
         n_fail++; $display("FAIL pause ticks/done_cycle: got %0d/%0d want 2/32", tick_count, done_cycle);
      end
   endtask

   task automatic test_prog_write();
      clear_knobs();
      prog_entry(0, 0, 1);
      prog_entry(1, 3, 1);
      prog_entry(2, 0, 0);
      prog_entry(3, 0, 0);
      wr_at = 8; wr_a = 1; wr_s = 0; wr_d = 5;
      stop_at = 36;
      start_run(1'b1);
      scoreboard_run(100, 1'b0, "prog_write");
      check_ticks("prog_write", '{2, 19, 23, 25, 26, 27, 28, 29});
   endtask

   task automatic test_async_reset();
      clear_knobs();
      program_example();
      start_run(1'b0);
      repeat (5) @(posedge clock_in);
      @(negedge clock_in);
      n_checks++;
      if (busy !== 1'b1 || speed !== 2'b01) begin
         n_fail++; $display("FAIL async_reset pre_state: got busy=%b speed=%0d want 1/1", busy, speed);
      end
      #2 resetn = 1'b0;
      #1 check_idle("async_reset");
      @(negedge clock_in); resetn = 1'b1;
      for (int i = 0; i < NS; i++) begin
         mem_s[i] = 0; mem_d[i] = 0;
      end
      @(posedge clock_in); #1;
      start_run(1'b0);
      scoreboard_run(50, 1'b1, "empty_prog");
      n_checks++;
      if (done_cycle != 5 || tick_count != 0) begin
         n_fail++; $display("FAIL empty_prog done_cycle/ticks: got %0d/%0d want 5/0", done_cycle, tick_count);
      end
   endtask

   task automatic test_random();
      bit lp;
      for (int it = 0; it < 20; it++) begin
         clear_knobs();
         for (int a = 0; a < NS; a++)
            prog_entry(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         lp        = 1'($urandom_range(0, 1));
         pause_pct = ($urandom_range(0, 1) == 1) ? 15 : 0;
         wr_pct    = ($urandom_range(0, 1) == 1) ? 5 : 0;
         stop_at   = lp ? int'($urandom_range(60, 300)) : 0;
         start_run(lp);
         scoreboard_run(600, !lp, "random");
      end
   endtask

   initial begin
      resetn = 1'b0;
      start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
      prog_write = 1'b0; prog_addr = '0; prog_speed = 2'b00; prog_dwell = '0;
      for (int i = 0; i < NS; i++) begin
         mem_s[i] = 0; mem_d[i] = 0;
      end
      clear_knobs();
      test_reset();
      test_single_pass();
      test_start_stop();
      test_loop_stop();
      test_zero_dwell();
      test_pause();
      test_prog_write();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
